// File: rtl/des_round_datapath.sv
// Iterative DES Feistel round datapath: holds L/R for one block, drives an external
// S-box bank with E(R)^subkey and folds P(sbox_out) back into the halves once per cycle.
module des_round_datapath #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] block_in,
  input  logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic [47:0] sbox_in,
  input  logic [31:0] sbox_out,
  output logic        busy,
  output logic        done,
  output logic [63:0] block_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  // Table entries are FIPS 46-3 positions, where position 1 is the MSB.
  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  logic [1:0]  state;
  logic [31:0] l_q;
  logic [31:0] r_q;
  logic [3:0]  round_q;
  logic [47:0] e_r;
  logic [31:0] p_out;
  logic        load_en;

  for (genvar i = 0; i < 48; i++) begin : g_expand
    assign e_r[47-i] = r_q[32-E_TBL[i]];
  end

  for (genvar i = 0; i < 32; i++) begin : g_perm
    assign p_out[31-i] = sbox_out[32-P_TBL[i]];
  end

  assign sbox_in = e_r ^ subkey;

  // A new block is accepted only when no block is in flight.
  assign load_en = start && (state != S_RUN);

  // NOTE: every register below is updated with <= so all of them sample the
  // pre-edge values of l_q/r_q; blocking assignments here would chain L into R.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      l_q     <= '0;
      r_q     <= '0;
      round_q <= '0;
    end else if (load_en) begin
      state   <= S_RUN;
      l_q     <= block_in[63:32];
      r_q     <= block_in[31:0];
      round_q <= '0;
    end else begin
      case (state)
        S_RUN: begin
          l_q <= r_q;
          r_q <= l_q ^ p_out;
          if (round_q == LAST_ROUND) begin
            state <= S_DONE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The halves are already registers, so {R, L} is the registered, pre-FP output.
  assign block_out = {r_q, l_q};
  assign round_idx = round_q;
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_des_round_datapath.sv
// Bench for des_round_datapath: supplies the DES S-box bank and key schedule and checks
// the datapath against published DES known-answer vectors.
module tb_des_round_datapath;

  localparam logic [63:0] KEY_A   = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] BLK_A   = 64'hCC00_CCFF_F0AA_F0AA;
  localparam logic [63:0] OUT_A   = 64'h0A4C_D995_4342_3234;
  localparam logic [63:0] CT_A    = 64'h85E8_1354_0F0A_B405;
  localparam logic [63:0] KEY_B   = 64'h0E32_9232_EA6D_0D73;
  localparam logic [63:0] PT_B    = 64'h8787_8787_8787_8787;
  localparam logic [63:0] CT_B    = 64'h0000_0000_0000_0000;

  localparam int SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
  };

  localparam int PC1 [56] = '{
    57,49,41,33,25,17, 9,  1,58,50,42,34,26,18, 10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
    63,55,47,39,31,23,15,  7,62,54,46,38,30,22, 14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4
  };

  localparam int PC2 [48] = '{
    14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32
  };

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int IP [64] = '{
    58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4, 62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
    57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3, 61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7
  };

  localparam int FP [64] = '{
    40, 8,48,16,56,24,64,32, 39, 7,47,15,55,23,63,31, 38, 6,46,14,54,22,62,30, 37, 5,45,13,53,21,61,29,
    36, 4,44,12,52,20,60,28, 35, 3,43,11,51,19,59,27, 34, 2,42,10,50,18,58,26, 33, 1,41, 9,49,17,57,25
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] block_in = '0;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic [47:0] sbox_in;
  logic [31:0] sbox_out;
  logic        busy;
  logic        done;
  logic [63:0] block_out;

  logic        start1 = 1'b0;
  logic [63:0] block_in1 = '0;
  logic [47:0] subkey1;
  logic [3:0]  round_idx1;
  logic [47:0] sbox_in1;
  logic [31:0] sbox_out1;
  logic        busy1;
  logic        done1;
  logic [63:0] block_out1;

  logic [47:0] ks [16];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] sbox_bank(input logic [47:0] x);
    logic [31:0] r;
    logic [5:0]  six;
    r = '0;
    for (int s = 0; s < 8; s++) begin
      six = x[47-6*s -: 6];
      r[31-4*s -: 4] = 4'(SBOX[s*64 + {six[5], six[0]}*16 + six[4:1]]);
    end
    return r;
  endfunction

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-IP[i]];
    return r;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-FP[i]];
    return r;
  endfunction

  task automatic set_key(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] k;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2[i]];
      ks[r] = k;
    end
  endtask

  assign subkey    = ks[round_idx];
  assign sbox_out  = sbox_bank(sbox_in);
  assign subkey1   = ks[round_idx1];
  assign sbox_out1 = sbox_bank(sbox_in1);

  des_round_datapath #(.ROUNDS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .block_in  (block_in),
    .subkey    (subkey),
    .round_idx (round_idx),
    .sbox_in   (sbox_in),
    .sbox_out  (sbox_out),
    .busy      (busy),
    .done      (done),
    .block_out (block_out)
  );

  des_round_datapath #(.ROUNDS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .block_in  (block_in1),
    .subkey    (subkey1),
    .round_idx (round_idx1),
    .sbox_in   (sbox_in1),
    .sbox_out  (sbox_out1),
    .busy      (busy1),
    .done      (done1),
    .block_out (block_out1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done, driving start each cycle as hold || (cycle == pulse_at).
  task automatic wait_done(input int budget, input logic hold, input int pulse_at,
                           output int n);
    n = 0;
    do begin
      step();
      n++;
      start = hold || (n == pulse_at);
    end while (!done && n < budget);
    check("done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    int          n;
    int          seen;
    logic [63:0] held;

    set_key(KEY_A);
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_block_out", block_out, 64'd0);
    check("rst_round_idx", 64'(round_idx), 64'd0);
    rst_n = 1'b1;
    step();

    // FIPS example block, single run.
    block_in = BLK_A;
    start = 1'b1;
    step();
    start = 1'b0;
    check("r0_round_idx", 64'(round_idx), 64'd0);
    check("r0_busy", 64'(busy), 64'd1);
    check("r0_sbox_in", 64'(sbox_in), 64'h6117_BA86_6527);
    step();
    check("r1_R", 64'(block_out[63:32]), 64'hEF4A_6544);
    check("r1_L", 64'(block_out[31:0]), 64'hF0AA_F0AA);
    check("r1_round_idx", 64'(round_idx), 64'd1);
    wait_done(40, 1'b0, -1, n);
    check("fips_latency", 64'(n + 1), 64'd16);
    check("fips_block_out", block_out, OUT_A);
    check("fips_ciphertext", fp_f(block_out), CT_A);
    check("fips_busy_in_done", 64'(busy), 64'd0);
    held = block_out;

    // Hold: start stays low after done.
    step();
    check("done_one_cycle", 64'(done), 64'd0);
    seen = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (done || busy) seen++;
    end
    check("hold_no_activity", 64'(seen), 64'd0);
    check("hold_busy", 64'(busy), 64'd0);
    check("hold_block_out", block_out, held);

    // start pulsed during round 5 must not disturb the block.
    block_in = BLK_A;
    start = 1'b1;
    step();
    block_in = ip_f(PT_B);
    wait_done(40, 1'b0, 5, n);
    check("ignored_start_latency", 64'(n), 64'd16);
    check("ignored_start_block_out", block_out, OUT_A);
    step();
    check("ignored_start_idle", 64'(busy), 64'd0);

    // Back-to-back: start held high, second block loads in the DONE cycle.
    block_in = BLK_A;
    start = 1'b1;
    step();
    wait_done(40, 1'b1, -1, n);
    check("b2b_a_latency", 64'(n), 64'd16);
    check("b2b_a_ciphertext", fp_f(block_out), CT_A);
    block_in = ip_f(PT_B);
    step();
    set_key(KEY_B);
    check("b2b_b_loaded_busy", 64'(busy), 64'd1);
    check("b2b_b_loaded_round", 64'(round_idx), 64'd0);
    wait_done(40, 1'b1, -1, n);
    start = 1'b0;
    check("b2b_b_latency", 64'(n), 64'd16);
    check("b2b_b_ciphertext", fp_f(block_out), CT_B);
    step();
    check("b2b_idle_after", 64'(busy), 64'd0);

    // Reset asserted during round 7.
    set_key(KEY_A);
    block_in = BLK_A;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("abort_round_reached", 64'(round_idx), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_block_out", block_out, 64'd0);
    check("abort_round_idx", 64'(round_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    // Single-round configuration.
    block_in1 = BLK_A;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("one_round_busy", 64'(busy1), 64'd1);
    check("one_round_idx0", 64'(round_idx1), 64'd0);
    step();
    check("one_round_done", 64'(done1), 64'd1);
    check("one_round_block_out", block_out1, 64'hEF4A_6544_F0AA_F0AA);
    check("one_round_idx1", 64'(round_idx1), 64'd0);
    step();
    check("one_round_done_drop", 64'(done1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_round_datapath.md
# des_round_datapath

Iterative 16-round DES Feistel datapath. Holds the L/R halves of one block and drives the external S-box bank (sbox1..sbox8, 6-in/4-out combinational lookups). Each round it forms E(R) XOR subkey for the S-boxes, applies the P permutation to their concatenated output, and updates the halves. It sits between the initial-permutation stage and the final-permutation stage, and takes per-round subkeys from the key schedule.

## Interface
- `ROUNDS`, 16, number of Feistel rounds executed per block (1..16).
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  load request; accepted only in IDLE or DONE.
- `block_in`  in  64  post-IP block; [63:32] = L0, [31:0] = R0.
- `subkey`  in  48  subkey for the round indexed by `round_idx`, supplied combinationally by the key schedule.
- `round_idx`  out  4  current round number (0..ROUNDS-1), registered.
- `sbox_in`  out  48  E(R) XOR subkey, combinational from registers and `subkey`. Bits [47:42] feed sbox1 … bits [5:0] feed sbox8.
- `sbox_out`  in  32  S-box bank result, same cycle. sbox1 drives [31:28] … sbox8 drives [3:0].
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse; `block_out` is valid.
- `block_out`  out  64  {R_final, L_final}, i.e. the pre-FP output with the final swap applied.

Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- **Bit numbering:** FIPS 46-3 bit 1 = MSB of each vector. E and P tables are exactly per FIPS 46-3.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE + `start`: L ← block_in[63:32], R ← block_in[31:0], round ← 0, go to RUN.
  - RUN, each cycle: L ← R; R ← L XOR P(sbox_out); round ← round+1.
  - When round == ROUNDS-1, perform the final round and go to DONE (round not incremented past ROUNDS-1).
  - DONE: `done` = 1 for one cycle.
    - `start` present: reload as in IDLE and go to RUN (back-to-back blocks).
    - Otherwise: go to IDLE.
- **`start` during RUN:** ignored; no reload, no effect on the running block.
- **`block_out`:** registered, equal to {R, L}. Holds its value in IDLE and DONE until the next load.
- **`sbox_in`:** E expands R 32→48. XOR with `subkey` is bitwise, with no width change.
- **Reset values:** L, R, round, `round_idx`, `block_out` = 0; `busy` = 0; `done` = 0; state = IDLE.
- **Reset asserted mid-RUN:** immediate abort; all outputs return to reset values, and no `done` is produced for the aborted block.

## Timing
- `start` is sampled at edge E0. `round_idx` = 0 is visible after E0.
- Round k (0-based) is committed at edge E(k+1).
- After E(ROUNDS): state = DONE, `done` = 1, `block_out` valid.
- Latency from `start` edge to `done` high: ROUNDS edges. Throughput: 1 block per ROUNDS cycles with back-to-back `start` in DONE.
- `sbox_in` → `sbox_out` → R is a single-cycle combinational path: E, XOR, S-box, P, XOR.
- `subkey` must be stable for the whole cycle in which `round_idx` shows its round.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-RUN (round 7) → `busy` = 0, `done` = 0, `block_out` = 0, `round_idx` = 0 immediately. No `done` follows after release.
- **FIPS vector (bench S-box bank and key schedule, key 133457799BBCDFF1):** block_in = CC00CCFF_F0AAF0AA.
  - Round 0: `sbox_in` = 6117BA866527, and R after E1 = EF4A6544.
  - `done` after 16 cycles with `block_out` = 0A4CD995_43423234.
  - After FP this gives ciphertext 85E813540F0AB405.
- **Ignored start:** `start` pulsed at round 5 → same `block_out` as the unpatterned run, `done` exactly 16 cycles after the original `start`.
- **Back-to-back:** `start` held high with two blocks → second block loads in the DONE cycle, second `done` 16 cycles later, and both results match the reference model.
- **ROUNDS = 1:** block_in = CC00CCFF_F0AAF0AA, K1 applied → `done` one cycle later with `block_out` = EF4A6544_F0AAF0AA, `round_idx` stays 0.
- **Hold:** after `done`, leave `start` low for 20 cycles → state IDLE, `block_out` unchanged, `busy` = 0.
